burst_rd_ctrl: RTL and testbench
================================

// Module: burst_rd_ctrl
// PURPOSE
//  Parametrised Avalon-MM burst read master. Moves one packet [pkt_begin, pkt_end) from HPS/SDRAM into the capture FIFO.
//  Splits the packet into bursts of at most MAX_BURST words and throttles on FIFO almost_full.
//  Sits between the control register slave (command in) and the capture FIFO (data out).
//  Pulses rd_ctrl_rdy when the last word has been written to the FIFO.
// PARAMETERS
//  DATA_W     32  Avalon readdata / fifo_in width in bits; multiple of 8, power of 2
//  ADDR_W     32  byte address width
//  MAX_BURST  16  max words per burst; power of 2, 1..2**(BURST_W-1)
//  BURST_W    16  burstcount port width
// PORTS
//  clk            in   1        system clock
//  reset          in   1        asynchronous reset, active low
//  rd_ctrl        in   1        start pulse; sampled only in IDLE
//  pkt_begin      in   ADDR_W   first byte address; low log2(DATA_W/8) bits ignored (forced 0)
//  pkt_end        in   ADDR_W   byte address one past last byte (exclusive)
//  almost_full    in   1        FIFO can no longer absorb a full MAX_BURST
//  fifo_in        out  DATA_W   data word to FIFO
//  wr_to_fifo     out  1        FIFO write strobe; one per word
//  rd_ctrl_rdy    out  1        1-cycle done pulse
//  busy           out  1        high in every state other than IDLE
//  address        out  ADDR_W   Avalon byte address
//  read           out  1        Avalon read request
//  burstcount     out  BURST_W  Avalon burst length in words
//  readdata       in   DATA_W   Avalon read data
//  readdatavalid  in   1        Avalon read data valid
//  waitrequest    in   1        Avalon stall
// BEHAVIOUR
//  Reset (async, low): state=IDLE; all outputs 0, including address, burstcount and fifo_in. All counters are 0.
//  B = DATA_W/8. On start, latch:
//    base  = pkt_begin & ~(B-1)
//    words = (pkt_end - base + B-1) >> log2(B), computed at ADDR_W width
//    If pkt_end <= pkt_begin, words = 0.
//  FSM:
//    IDLE   -> if rd_ctrl: latch inputs; words==0 ? DONE : ISSUE.
//    ISSUE  -> If almost_full: read=0, wait in ISSUE.
//              Else read=1, address=base+off*B, burstcount=min(MAX_BURST, words_left).
//              address, burstcount and read are held stable while waitrequest=1.
//              Accept (read && !waitrequest) -> DATA; latch blen=burstcount, off+=blen, words_left-=blen.
//              read and address are not recomputed mid-request.
//    DATA   -> Each readdatavalid: fifo_in<=readdata, wr_to_fifo=1 next cycle (latency 1); beat++.
//              On the final beat (beat==blen-1 with valid): words_left==0 ? DONE : ISSUE.
//              readdatavalid is accepted regardless of almost_full; the FIFO headroom guarantees space.
//    DONE   -> rd_ctrl_rdy=1 for exactly 1 cycle, then IDLE.
//  Outputs are registered; read is deasserted the cycle after accept. Only one burst is outstanding at a time.
//  rd_ctrl while busy is ignored; pkt_begin/pkt_end changes mid-packet have no effect.
//  readdatavalid in IDLE or ISSUE is dropped, with no FIFO write.
//  Offset/word arithmetic uses ADDR_W bits; address wraps modulo 2**ADDR_W.
//  Reset mid-burst: immediate return to IDLE with outputs 0. Late readdatavalid beats are then dropped.
//  Last burst may be shorter than MAX_BURST. The final partial word is written whole; there is no byte masking.
// TESTING
//  T1 begin=0x1000, end=0x1010, DATA_W=32, MAX_BURST=16:
//     one burst, addr 0x1000, burstcount 4; 4 wr_to_fifo; rd_ctrl_rdy 1 cycle after the 4th write.
//  T2 begin=0x2000, end=0x2000+4*40:
//     bursts 16,16,8 at 0x2000, 0x2040, 0x2080; 40 writes in order; one rd_ctrl_rdy.
//  T3 waitrequest=1 for 5 cycles on burst 2:
//     address and burstcount stable throughout; no extra request; data order intact.
//  T4 almost_full held during ISSUE: read stays 0 until it is released.
//     almost_full asserted during DATA: all beats are still written.
//  T5 end<=begin, or end=begin+1 (unaligned):
//     0 words -> rd_ctrl_rdy with no read; 1 byte -> 1-word burst, 1 write.
//  T6 reset low mid-DATA: outputs 0 asynchronously; stray readdatavalid gives no write.
//     A new rd_ctrl afterwards completes normally.

Source files
------------

// File: rtl/burst_rd_ctrl.sv
// Avalon-MM burst read master: fetches packet [pkt_begin, pkt_end) into the capture FIFO in bursts of <= MAX_BURST words.
// Latency: request one cycle after entering ISSUE; FIFO write one cycle after each readdatavalid; done pulse one cycle after DONE.
// Backpressure: holds the request while waitrequest=1; no new burst while almost_full=1; data beats always accepted.
module burst_rd_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int BURST_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_ctrl,
  input  logic [ADDR_W-1:0]  pkt_begin,
  input  logic [ADDR_W-1:0]  pkt_end,
  input  logic               almost_full,
  output logic [DATA_W-1:0]  fifo_in,
  output logic               wr_to_fifo,
  output logic               rd_ctrl_rdy,
  output logic               busy,
  output logic [ADDR_W-1:0]  address,
  output logic               read,
  output logic [BURST_W-1:0] burstcount,
  input  logic [DATA_W-1:0]  readdata,
  input  logic               readdatavalid,
  input  logic               waitrequest
);

  localparam int B  = DATA_W / 8;
  localparam int LB = $clog2(B);
  localparam logic [ADDR_W-1:0] BMASK  = ADDR_W'(B - 1);
  localparam logic [ADDR_W-1:0] MAXB_A = ADDR_W'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DATA, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [ADDR_W-1:0]    off_q, off_d;
  logic [ADDR_W-1:0]    left_q, left_d;
  logic [BURST_W-1:0]   blen_q, blen_d;
  logic [BURST_W-1:0]   beat_q, beat_d;
  logic                 read_q, read_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BURST_W-1:0]   bc_q, bc_d;
  logic [DATA_W-1:0]    fifo_q, fifo_d;
  logic                 wr_q, wr_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;

  logic [ADDR_W-1:0]    start_base;
  logic [ADDR_W-1:0]    start_words;
  logic [BURST_W-1:0]   burst_len;
  logic                 accept;
  logic                 last_beat;

  // Packet geometry at start, next burst length, and handshake events
  always_comb begin
    start_base  = pkt_begin & ~BMASK;
    start_words = (pkt_end <= pkt_begin) ? '0 : ((pkt_end - start_base + BMASK) >> LB);
    burst_len   = (left_q >= MAXB_A) ? BURST_W'(MAX_BURST) : left_q[BURST_W-1:0];
    accept      = read_q & ~waitrequest;
    last_beat   = readdatavalid && (beat_q == blen_q - BURST_W'(1));
  end

  // State and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      off_q   <= '0;
      left_q  <= '0;
      blen_q  <= '0;
      beat_q  <= '0;
      read_q  <= 1'b0;
      addr_q  <= '0;
      bc_q    <= '0;
      fifo_q  <= '0;
      wr_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      off_q   <= off_d;
      left_q  <= left_d;
      blen_q  <= blen_d;
      beat_q  <= beat_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      bc_q    <= bc_d;
      fifo_q  <= fifo_d;
      wr_q    <= wr_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: one burst outstanding at a time, back to ISSUE until no words remain
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rd_ctrl) state_d = (start_words == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (accept) state_d = S_DATA;
      S_DATA:  if (last_beat) state_d = (left_q == '0) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath: request is frozen once raised until accepted
  always_comb begin
    base_d = base_q;
    off_d  = off_q;
    left_d = left_q;
    blen_d = blen_q;
    beat_d = beat_q;
    read_d = read_q;
    addr_d = addr_q;
    bc_d   = bc_q;
    fifo_d = fifo_q;
    wr_d   = 1'b0;
    rdy_d  = (state_q == S_DONE);
    busy_d = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        read_d = 1'b0;
        if (rd_ctrl) begin
          base_d = start_base;
          left_d = start_words;
          off_d  = '0;
          beat_d = '0;
        end
      end
      S_ISSUE: begin
        if (!read_q) begin
          if (!almost_full) begin
            read_d = 1'b1;
            addr_d = base_q + (off_q << LB);
            bc_d   = burst_len;
          end
        end else if (!waitrequest) begin
          read_d = 1'b0;
          blen_d = bc_q;
          off_d  = off_q + ADDR_W'(bc_q);
          left_d = left_q - ADDR_W'(bc_q);
          beat_d = '0;
        end
      end
      S_DATA: begin
        if (readdatavalid) begin
          fifo_d = readdata;
          wr_d   = 1'b1;
          beat_d = beat_q + BURST_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign fifo_in     = fifo_q;
  assign wr_to_fifo  = wr_q;
  assign rd_ctrl_rdy = rdy_q;
  assign busy        = busy_q;
  assign address     = addr_q;
  assign read        = read_q;
  assign burstcount  = bc_q;

endmodule

// File: tb/tb_burst_rd_ctrl.sv
// Randomised bench for burst_rd_ctrl: Avalon slave model with random stalls/gaps, packet-level reference model.
// Latency: checks are taken on the falling edge; inputs for the next rising edge are driven there too.
// Backpressure: random waitrequest, almost_full and readdatavalid gaps; fixed-stall and forced-full scenarios.
module tb_burst_rd_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_ctrl;
  logic [31:0] pkt_begin, pkt_end;
  logic        almost_full;
  logic [31:0] fifo_in;
  logic        wr_to_fifo, rd_ctrl_rdy, busy;
  logic [31:0] address;
  logic        read;
  logic [15:0] burstcount;
  logic [31:0] readdata;
  logic        readdatavalid, waitrequest;

  burst_rd_ctrl #(.DATA_W(32), .ADDR_W(32), .MAX_BURST(16), .BURST_W(16)) dut (
    .clk(clk), .reset(reset), .rd_ctrl(rd_ctrl), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .almost_full(almost_full), .fifo_in(fifo_in), .wr_to_fifo(wr_to_fifo), .rd_ctrl_rdy(rd_ctrl_rdy),
    .busy(busy), .address(address), .read(read), .burstcount(burstcount), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference expectations
  logic [31:0] exp_addr_q[$];
  int          exp_len_q[$];
  logic [31:0] exp_dat_q[$];
  // slave model: addresses of beats still owed to the master
  logic [31:0] beat_q[$];

  int  wr_pct, af_pct, dv_pct, af_force_cnt;
  bit  t3_mode, stray_all, start_now;
  int  req_idx, wait_cnt, rdy_cnt, wr_seen;
  bit  prev_hold, prev_read, af_prev;
  logic [31:0] prev_addr;
  logic [15:0] prev_bc;
  logic [31:0] cur_b, cur_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // packet -> list of bursts and word stream, straight from the address rules
  task automatic plan(input logic [31:0] b, input logic [31:0] e);
    longint base, words, off, n;
    base  = b & 32'hFFFF_FFFC;
    words = (e <= b) ? 0 : (longint'(e) - base + 3) / 4;
    off = 0;
    while (off < words) begin
      n = (words - off > 16) ? 16 : words - off;
      exp_addr_q.push_back(32'(base + off * 4));
      exp_len_q.push_back(int'(n));
      off += n;
    end
    for (longint i = 0; i < words; i++) exp_dat_q.push_back(mem_word(32'(base + i * 4)));
  endtask

  task automatic cycle();
    bit accepted_now;
    @(negedge clk);
    // ---- monitor
    if (wr_to_fifo) begin
      wr_seen++;
      if (exp_dat_q.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
      else chk("fifo_data", fifo_in, exp_dat_q.pop_front());
    end
    if (rd_ctrl_rdy) begin
      rdy_cnt++;
      chk("rdy_after_last_wr", exp_dat_q.size(), 32'd0);
      chk("busy_at_rdy", {31'd0, busy}, 32'd0);
    end
    if (prev_hold) begin
      chk("hold_read", {31'd0, read}, 32'd1);
      chk("hold_addr", address, prev_addr);
      chk("hold_bc", {16'd0, burstcount}, {16'd0, prev_bc});
    end
    if (read && !prev_read) chk("af_gate", {31'd0, af_prev}, 32'd0);
    // ---- drive slave side
    accepted_now = 1'b0;
    if (read) begin
      if (beat_q.size() != 0) chk("two_outstanding", 32'd1, 32'd0);
      wait_cnt++;
      if (t3_mode && req_idx == 1) waitrequest = (wait_cnt <= 5);
      else waitrequest = ($urandom_range(99) < wr_pct);
      if (!waitrequest) begin
        accepted_now = 1'b1;
        if (exp_addr_q.size() == 0) chk("extra_request", 32'd1, 32'd0);
        else begin
          chk("req_addr", address, exp_addr_q.pop_front());
          chk("req_bc", {16'd0, burstcount}, 32'(exp_len_q.pop_front()));
        end
        for (int i = 0; i < int'(burstcount); i++) beat_q.push_back(address + 32'(4 * i));
        req_idx++;
        wait_cnt = 0;
      end
    end else begin
      waitrequest = 1'($urandom_range(1));
    end
    prev_hold = read && waitrequest;
    prev_addr = address;
    prev_bc   = burstcount;
    prev_read = read;
    readdatavalid = 1'b0;
    readdata      = $urandom;
    if (!accepted_now) begin
      if (beat_q.size() != 0) begin
        if ($urandom_range(99) < dv_pct) begin
          readdatavalid = 1'b1;
          readdata      = mem_word(beat_q.pop_front());
        end
      end else if ((!busy || read) && (stray_all || $urandom_range(9) == 0)) begin
        readdatavalid = 1'b1;
      end
    end
    if (af_force_cnt > 0) begin
      almost_full = 1'b1;
      af_force_cnt--;
    end else begin
      almost_full = ($urandom_range(99) < af_pct);
    end
    af_prev = almost_full;
    // ---- command side
    if (start_now) begin
      rd_ctrl = 1'b1;
      pkt_begin = cur_b;
      pkt_end   = cur_e;
    end else begin
      rd_ctrl = busy && ($urandom_range(9) == 0);
      if (busy) begin
        pkt_begin = $urandom;
        pkt_end   = $urandom;
      end
    end
  endtask

  task automatic start_pkt(input logic [31:0] b, input logic [31:0] e);
    plan(b, e);
    cur_b = b;
    cur_e = e;
    rdy_cnt = 0;
    req_idx = 0;
    wait_cnt = 0;
    start_now = 1'b1;
    cycle();
    start_now = 1'b0;
  endtask

  task automatic run_pkt(input logic [31:0] b, input logic [31:0] e);
    int n;
    start_pkt(b, e);
    n = 0;
    while (rdy_cnt == 0 && n < 3000) begin
      cycle();
      n++;
    end
    chk("done_in_time", {31'd0, rdy_cnt != 0}, 32'd1);
    repeat (3) cycle();
    chk("rdy_pulses", 32'(rdy_cnt), 32'd1);
    chk("bursts_left", exp_addr_q.size(), 32'd0);
    chk("words_left", exp_dat_q.size(), 32'd0);
    exp_addr_q.delete();
    exp_len_q.delete();
    exp_dat_q.delete();
    beat_q.delete();
  endtask

  initial begin
    int n, w0;
    logic [31:0] b, len;
    reset = 1'b0; rd_ctrl = 1'b0; pkt_begin = '0; pkt_end = '0; almost_full = 1'b0;
    readdata = '0; readdatavalid = 1'b0; waitrequest = 1'b0;
    wr_pct = 0; af_pct = 0; dv_pct = 100; af_force_cnt = 0;
    t3_mode = 0; stray_all = 0; start_now = 0;
    prev_hold = 0; prev_read = 0; af_prev = 0; wr_seen = 0;
    #12;
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_addr", address, 32'd0);
    chk("rst_bc", {16'd0, burstcount}, 32'd0);
    chk("rst_fifo_in", fifo_in, 32'd0);
    chk("rst_wr", {31'd0, wr_to_fifo}, 32'd0);
    chk("rst_rdy", {31'd0, rd_ctrl_rdy}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) cycle();

    // T1: single short burst, ideal slave
    run_pkt(32'h1000, 32'h1010);
    // T2: 40 words -> 16,16,8 with random stalls
    wr_pct = 30; af_pct = 10; dv_pct = 70;
    run_pkt(32'h2000, 32'h2000 + 4 * 40);
    // T3: second burst held off by 5 cycles of waitrequest
    t3_mode = 1;
    run_pkt(32'h3000, 32'h3000 + 4 * 40);
    t3_mode = 0;
    // T4: almost_full forced at start, then heavy random almost_full
    af_pct = 60;
    af_force_cnt = 15;
    run_pkt(32'h4000, 32'h4000 + 4 * 50);
    af_pct = 10;
    // T5: empty, reversed and unaligned tiny packets
    run_pkt(32'h5000, 32'h5000);
    run_pkt(32'h5008, 32'h5004);
    run_pkt(32'h5001, 32'h5002);
    run_pkt(32'h5003, 32'h5005);
    run_pkt(32'h5002, 32'h5047);

    // T6: reset mid-DATA, stray beats dropped, then a clean packet
    start_pkt(32'h6000, 32'h6000 + 4 * 40);
    w0 = exp_dat_q.size();
    n = 0;
    while (exp_dat_q.size() > w0 - 5 && n < 1000) begin
      cycle();
      n++;
    end
    chk("t6_reached_data", {31'd0, exp_dat_q.size() <= w0 - 5}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_read", {31'd0, read}, 32'd0);
    chk("arst_addr", address, 32'd0);
    chk("arst_bc", {16'd0, burstcount}, 32'd0);
    chk("arst_fifo_in", fifo_in, 32'd0);
    chk("arst_wr", {31'd0, wr_to_fifo}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    exp_addr_q.delete();
    exp_len_q.delete();
    exp_dat_q.delete();
    beat_q.delete();
    prev_hold = 0;
    prev_read = 0;
    stray_all = 1;
    wr_seen = 0;
    repeat (4) cycle();
    reset = 1'b1;
    repeat (4) cycle();
    chk("stray_wr", 32'(wr_seen), 32'd0);
    chk("idle_after_rst", {31'd0, busy}, 32'd0);
    stray_all = 0;
    run_pkt(32'h6100, 32'h6100 + 4 * 20);

    // random packets
    for (int k = 0; k < 10; k++) begin
      wr_pct = $urandom_range(50);
      af_pct = $urandom_range(40);
      dv_pct = 30 + $urandom_range(70);
      b   = $urandom_range(32'h00FF_FFFF);
      len = $urandom_range(300);
      if ($urandom_range(7) == 0) run_pkt(b, b - len);
      else run_pkt(b, b + len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
